// File: rtl/tcp_app_pkg.sv
// Shared TCP application-interface definitions: notification, read_package and
// endpoint header layouts plus the rx notification handler state encoding.
package tcp_app_pkg;

    localparam int unsigned SESS_W  = 16;
    localparam int unsigned LEN_W   = 16;
    localparam int unsigned IP_W    = 32;
    localparam int unsigned PORT_W  = 16;

    localparam int unsigned NOTIF_W  = 88;
    localparam int unsigned RDPKG_W  = 32;
    localparam int unsigned EPHDR_W  = 32;

    localparam int unsigned NOTIF_SESS_LSB   = 0;
    localparam int unsigned NOTIF_LEN_LSB    = 16;
    localparam int unsigned NOTIF_IP_LSB     = 32;
    localparam int unsigned NOTIF_PORT_LSB   = 64;
    localparam int unsigned NOTIF_CLOSED_BIT = 80;

    localparam int unsigned HDR_SESS_LSB = 0;
    localparam int unsigned HDR_LEN_LSB  = 16;

    localparam logic [15:0] SAT_MAX = '1;

    typedef struct packed {
        logic [6:0]        pad;
        logic              closed;
        logic [PORT_W-1:0] port;
        logic [IP_W-1:0]   ip;
        logic [LEN_W-1:0]  length;
        logic [SESS_W-1:0] session;
    } tcp_notif_t;

    typedef struct packed {
        logic [LEN_W-1:0]  length;
        logic [SESS_W-1:0] session;
    } tcp_rdpkg_t;

    typedef struct packed {
        logic [LEN_W-1:0]  length;
        logic [SESS_W-1:0] session;
    } ep_hdr_t;

    typedef enum logic [2:0] {
        RXH_IDLE,
        RXH_REQ,
        RXH_META,
        RXH_HDR,
        RXH_DATA
    } rxh_state_t;

endpackage

// File: rtl/tcp_keep_popcount.sv
// Combinational population count of a byte-enable vector.
module tcp_keep_popcount #(
    parameter int unsigned N = 64
) (
    input  logic [N-1:0]             keep,
    output logic [$clog2(N+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(N + 1);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < N; i++) begin
            count = count + CW'(keep[i]);
        end
    end

endmodule

// File: rtl/tcp_rx_notification_handler.sv
// Turns TCP rx notifications into read_package requests and frames each payload
// towards the endpoint as one header beat plus a pass-through data stream.
module tcp_rx_notification_handler
    import tcp_app_pkg::*;
#(
    parameter int unsigned WIDTH      = 512,
    parameter int unsigned STAT_WIDTH = 32
) (
    input  logic                    net_clk,
    input  logic                    net_rst,

    input  logic                    s_notif_valid,
    output logic                    s_notif_ready,
    input  logic [87:0]             s_notif_data,

    output logic                    m_rdpkg_valid,
    input  logic                    m_rdpkg_ready,
    output logic [31:0]             m_rdpkg_data,

    input  logic                    s_rxmeta_valid,
    output logic                    s_rxmeta_ready,
    input  logic [15:0]             s_rxmeta_data,

    input  logic                    s_rxdata_valid,
    output logic                    s_rxdata_ready,
    input  logic [WIDTH-1:0]        s_rxdata_data,
    input  logic [WIDTH/8-1:0]      s_rxdata_keep,
    input  logic                    s_rxdata_last,

    output logic                    m_ephdr_valid,
    input  logic                    m_ephdr_ready,
    output logic [31:0]             m_ephdr_data,

    output logic                    m_epdata_valid,
    input  logic                    m_epdata_ready,
    output logic [WIDTH-1:0]        m_epdata_data,
    output logic [WIDTH/8-1:0]      m_epdata_keep,
    output logic                    m_epdata_last,

    output logic                    close_valid,
    output logic [15:0]             close_session,
    output logic [STAT_WIDTH-1:0]   stat_pkts,
    output logic [STAT_WIDTH-1:0]   stat_bytes,
    output logic [15:0]             stat_len_err,
    output logic [15:0]             stat_sess_err
);

    localparam int unsigned KW = WIDTH / 8;
    localparam int unsigned CW = $clog2(KW + 1);

    rxh_state_t   state, next_state;
    tcp_notif_t   notif;
    logic [15:0]  sess_q, len_q;
    logic [16:0]  acc;
    logic [16:0]  pkt_total;
    logic [CW-1:0] beat_bytes;

    logic notif_hs, meta_hs, data_hs;
    logic notif_take;

    assign notif = tcp_notif_t'(s_notif_data);

    tcp_keep_popcount #(.N(KW)) u_popcount (
        .keep  (s_rxdata_keep),
        .count (beat_bytes)
    );

    assign notif_hs   = s_notif_valid & s_notif_ready;
    assign meta_hs    = s_rxmeta_valid & s_rxmeta_ready;
    assign data_hs    = s_rxdata_valid & s_rxdata_ready;
    assign notif_take = notif_hs & ~notif.closed & (notif.length != '0);
    assign pkt_total  = acc + 17'(beat_bytes);

    assign m_rdpkg_data  = tcp_rdpkg_t'{length: len_q, session: sess_q};
    assign m_ephdr_data  = ep_hdr_t'{length: len_q, session: sess_q};
    assign m_epdata_data = s_rxdata_data;
    assign m_epdata_keep = s_rxdata_keep;
    assign m_epdata_last = s_rxdata_last;

    always_ff @(posedge net_clk) begin
        if (net_rst) begin
            state <= RXH_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        s_notif_ready  = 1'b0;
        m_rdpkg_valid  = 1'b0;
        s_rxmeta_ready = 1'b0;
        m_ephdr_valid  = 1'b0;
        m_epdata_valid = 1'b0;
        s_rxdata_ready = 1'b0;
        unique case (state)
            RXH_IDLE: begin
                // Held low while reset is asserted so no notification slips in.
                s_notif_ready = ~net_rst;
                if (notif_take) next_state = RXH_REQ;
            end
            RXH_REQ: begin
                m_rdpkg_valid = 1'b1;
                if (m_rdpkg_ready) next_state = RXH_META;
            end
            RXH_META: begin
                s_rxmeta_ready = 1'b1;
                if (s_rxmeta_valid) next_state = RXH_HDR;
            end
            RXH_HDR: begin
                m_ephdr_valid = 1'b1;
                if (m_ephdr_ready) next_state = RXH_DATA;
            end
            RXH_DATA: begin
                m_epdata_valid = s_rxdata_valid;
                s_rxdata_ready = m_epdata_ready;
                if (data_hs && s_rxdata_last) next_state = RXH_IDLE;
            end
            default: next_state = RXH_IDLE;
        endcase
    end

    always_ff @(posedge net_clk) begin
        if (net_rst) begin
            sess_q        <= '0;
            len_q         <= '0;
            acc           <= '0;
            close_valid   <= 1'b0;
            close_session <= '0;
            stat_pkts     <= '0;
            stat_bytes    <= '0;
            stat_len_err  <= '0;
            stat_sess_err <= '0;
        end else begin
            close_valid <= notif_hs & notif.closed;
            if (notif_hs && notif.closed) begin
                close_session <= notif.session;
            end
            if (notif_take) begin
                sess_q <= notif.session;
                len_q  <= notif.length;
            end
            if (meta_hs) begin
                acc <= '0;
                if (s_rxmeta_data != sess_q && stat_sess_err != SAT_MAX) begin
                    stat_sess_err <= stat_sess_err + 16'd1;
                end
            end
            if (data_hs) begin
                acc <= pkt_total;
                // The closing beat's own bytes are folded in here, not via acc.
                if (s_rxdata_last) begin
                    stat_pkts  <= stat_pkts + STAT_WIDTH'(1);
                    stat_bytes <= stat_bytes + STAT_WIDTH'(pkt_total);
                    if (pkt_total != {1'b0, len_q} && stat_len_err != SAT_MAX) begin
                        stat_len_err <= stat_len_err + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tcp_rx_notification_handler.sv
// Directed self-checking bench for tcp_rx_notification_handler.
module tb_tcp_rx_notification_handler;

    localparam int unsigned WIDTH = 512;
    localparam int unsigned KW    = WIDTH / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_notif_valid, s_notif_ready;
    logic [87:0]       s_notif_data;
    logic              m_rdpkg_valid, m_rdpkg_ready;
    logic [31:0]       m_rdpkg_data;
    logic              s_rxmeta_valid, s_rxmeta_ready;
    logic [15:0]       s_rxmeta_data;
    logic              s_rxdata_valid, s_rxdata_ready;
    logic [WIDTH-1:0]  s_rxdata_data;
    logic [KW-1:0]     s_rxdata_keep;
    logic              s_rxdata_last;
    logic              m_ephdr_valid, m_ephdr_ready;
    logic [31:0]       m_ephdr_data;
    logic              m_epdata_valid, m_epdata_ready;
    logic [WIDTH-1:0]  m_epdata_data;
    logic [KW-1:0]     m_epdata_keep;
    logic              m_epdata_last;
    logic              close_valid;
    logic [15:0]       close_session;
    logic [31:0]       stat_pkts, stat_bytes;
    logic [15:0]       stat_len_err, stat_sess_err;

    int checks = 0;
    int errors = 0;

    tcp_rx_notification_handler #(.WIDTH(WIDTH), .STAT_WIDTH(32)) dut (
        .net_clk        (clk),
        .net_rst        (rst),
        .s_notif_valid  (s_notif_valid),
        .s_notif_ready  (s_notif_ready),
        .s_notif_data   (s_notif_data),
        .m_rdpkg_valid  (m_rdpkg_valid),
        .m_rdpkg_ready  (m_rdpkg_ready),
        .m_rdpkg_data   (m_rdpkg_data),
        .s_rxmeta_valid (s_rxmeta_valid),
        .s_rxmeta_ready (s_rxmeta_ready),
        .s_rxmeta_data  (s_rxmeta_data),
        .s_rxdata_valid (s_rxdata_valid),
        .s_rxdata_ready (s_rxdata_ready),
        .s_rxdata_data  (s_rxdata_data),
        .s_rxdata_keep  (s_rxdata_keep),
        .s_rxdata_last  (s_rxdata_last),
        .m_ephdr_valid  (m_ephdr_valid),
        .m_ephdr_ready  (m_ephdr_ready),
        .m_ephdr_data   (m_ephdr_data),
        .m_epdata_valid (m_epdata_valid),
        .m_epdata_ready (m_epdata_ready),
        .m_epdata_data  (m_epdata_data),
        .m_epdata_keep  (m_epdata_keep),
        .m_epdata_last  (m_epdata_last),
        .close_valid    (close_valid),
        .close_session  (close_session),
        .stat_pkts      (stat_pkts),
        .stat_bytes     (stat_bytes),
        .stat_len_err   (stat_len_err),
        .stat_sess_err  (stat_sess_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [87:0] mk_notif(input logic [15:0] sess, input logic [15:0] len, input logic closed);
        return {7'd0, closed, 16'h1F90, 32'hC0A8_0001, len, sess};
    endfunction

    task automatic check_stats(input string tag, input int pkts, input int bytes, input int len_err, input int sess_err);
        check({tag, "_pkts"}, stat_pkts, pkts);
        check({tag, "_bytes"}, stat_bytes, bytes);
        check({tag, "_len_err"}, stat_len_err, len_err);
        check({tag, "_sess_err"}, stat_sess_err, sess_err);
    endtask

    // Drives one notification through REQ/META/HDR, called and returning at a negedge.
    task automatic do_req(input logic [15:0] sess, input logic [15:0] len, input logic [15:0] meta);
        s_notif_valid = 1'b1;
        s_notif_data  = mk_notif(sess, len, 1'b0);
        #1;
        check("idle_notif_ready", s_notif_ready, 1);
        check("rdpkg_not_early", m_rdpkg_valid, 0);
        next_cycle();
        s_notif_valid = 1'b0;
        #1;
        check("rdpkg_valid", m_rdpkg_valid, 1);
        check("rdpkg_data", m_rdpkg_data, {len, sess});
        check("busy_notif_ready", s_notif_ready, 0);
        m_rdpkg_ready = 1'b1;
        next_cycle();
        m_rdpkg_ready = 1'b0;
        #1;
        check("rdpkg_dropped", m_rdpkg_valid, 0);
        check("rxmeta_ready", s_rxmeta_ready, 1);
        s_rxmeta_valid = 1'b1;
        s_rxmeta_data  = meta;
        next_cycle();
        s_rxmeta_valid = 1'b0;
        #1;
        check("hdr_valid", m_ephdr_valid, 1);
        check("hdr_data", m_ephdr_data, {len, sess});
        check("meta_ready_off", s_rxmeta_ready, 0);
        next_cycle();
        check("hdr_held", m_ephdr_valid, 1);
        check("hdr_data_held", m_ephdr_data, {len, sess});
        m_ephdr_ready = 1'b1;
        next_cycle();
        m_ephdr_ready = 1'b0;
        #1;
        check("hdr_once", m_ephdr_valid, 0);
    endtask

    task automatic send_beat(input logic [WIDTH-1:0] data, input logic [KW-1:0] keep, input logic last);
        s_rxdata_valid = 1'b1;
        s_rxdata_data  = data;
        s_rxdata_keep  = keep;
        s_rxdata_last  = last;
        m_epdata_ready = 1'b1;
        #1;
        check("ep_valid", m_epdata_valid, 1);
        check("rx_ready", s_rxdata_ready, 1);
        check("ep_data", m_epdata_data, data);
        check("ep_keep", m_epdata_keep, keep);
        check("ep_last", m_epdata_last, last);
        next_cycle();
        s_rxdata_valid = 1'b0;
        s_rxdata_last  = 1'b0;
        m_epdata_ready = 1'b0;
    endtask

    task automatic rand_word(output logic [WIDTH-1:0] w);
        for (int i = 0; i < int'(WIDTH / 32); i++) w[i*32 +: 32] = $urandom();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] beat [2];
        logic [WIDTH-1:0] w;
        logic [KW-1:0]    k36;
        int b;

        rst = 1'b1;
        s_notif_valid = 0; s_notif_data = '0;
        m_rdpkg_ready = 0;
        s_rxmeta_valid = 0; s_rxmeta_data = '0;
        s_rxdata_valid = 0; s_rxdata_data = '0; s_rxdata_keep = '0; s_rxdata_last = 0;
        m_ephdr_ready = 0; m_epdata_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        check("rst_notif_ready", s_notif_ready, 0);
        check("rst_rdpkg_valid", m_rdpkg_valid, 0);
        check("rst_close_valid", close_valid, 0);
        check("rst_close_session", close_session, 0);
        check_stats("rst", 0, 0, 0, 0);
        rst = 1'b0;

        // 1: single full beat
        do_req(16'd5, 16'd64, 16'd5);
        rand_word(w);
        send_beat(w, '1, 1'b1);
        check("t1_ep_valid_off", m_epdata_valid, 0);
        check("t1_idle_again", s_notif_ready, 1);
        check_stats("t1", 1, 64, 0, 0);

        // 2: close notification, then a zero-length one on the following cycle (3)
        s_notif_valid = 1'b1;
        s_notif_data  = mk_notif(16'd9, 16'd0, 1'b1);
        next_cycle();
        s_notif_data  = mk_notif(16'd21, 16'd0, 1'b0);
        #1;
        check("t2_close_valid", close_valid, 1);
        check("t2_close_session", close_session, 9);
        check("t2_no_rdpkg", m_rdpkg_valid, 0);
        check("t2_notif_ready", s_notif_ready, 1);
        next_cycle();
        s_notif_valid = 1'b0;
        #1;
        check("t3_close_pulse_end", close_valid, 0);
        check("t3_close_session_held", close_session, 9);
        check("t3_no_rdpkg", m_rdpkg_valid, 0);
        check("t3_notif_ready", s_notif_ready, 1);
        check_stats("t3", 1, 64, 0, 0);

        // 4: two beats with endpoint ready toggling every cycle
        do_req(16'd7, 16'd100, 16'd7);
        rand_word(beat[0]);
        rand_word(beat[1]);
        k36 = 64'h0000_000F_FFFF_FFFF;
        b = 0;
        m_epdata_ready = 1'b0;
        for (int c = 0; c < 12 && b < 2; c++) begin
            s_rxdata_valid = 1'b1;
            s_rxdata_data  = beat[b];
            s_rxdata_keep  = (b == 0) ? '1 : k36;
            s_rxdata_last  = (b == 1);
            #1;
            check("t4_ep_valid", m_epdata_valid, 1);
            check("t4_rx_ready", s_rxdata_ready, m_epdata_ready);
            check("t4_ep_data", m_epdata_data, beat[b]);
            check("t4_ep_last", m_epdata_last, (b == 1));
            @(posedge clk);
            if (m_epdata_ready) b++;
            @(negedge clk);
            m_epdata_ready = ~m_epdata_ready;
        end
        s_rxdata_valid = 1'b0;
        s_rxdata_last  = 1'b0;
        m_epdata_ready = 1'b0;
        check("t4_beats_done", b, 2);
        #1;
        check_stats("t4", 2, 164, 0, 0);

        // 5: metadata session mismatch, holey keep
        do_req(16'd3, 16'd8, 16'd4);
        rand_word(w);
        send_beat(w, 64'hF0F0, 1'b1);
        check_stats("t5", 3, 172, 0, 1);

        // 6: reset mid-DATA, then a short packet with a length error
        do_req(16'd11, 16'd64, 16'd11);
        rand_word(w);
        s_rxdata_valid = 1'b1;
        s_rxdata_data  = w;
        s_rxdata_keep  = '1;
        m_epdata_ready = 1'b0;
        #1;
        check("t6_in_data", m_epdata_valid, 1);
        rst = 1'b1;
        next_cycle();
        check("t6_notif_ready", s_notif_ready, 0);
        check("t6_rdpkg_valid", m_rdpkg_valid, 0);
        check("t6_rxmeta_ready", s_rxmeta_ready, 0);
        check("t6_hdr_valid", m_ephdr_valid, 0);
        check("t6_ep_valid", m_epdata_valid, 0);
        check("t6_rx_ready", s_rxdata_ready, 0);
        check("t6_close_valid", close_valid, 0);
        check_stats("t6_rst", 0, 0, 0, 0);
        rst = 1'b0;
        s_rxdata_valid = 1'b0;
        #1;
        check("t6_idle", s_notif_ready, 1);
        next_cycle();
        do_req(16'd12, 16'd10, 16'd12);
        rand_word(w);
        send_beat(w, 64'hFF, 1'b1);
        check_stats("t6", 1, 8, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
